// File: rtl/rom_scan_serializer_pkg.sv
// rom_scan_pkg: shared types and constants for the ROM scan serializer.
//   - state_e : scan FSM states (IDLE, FETCH, SHIFT, DONE)
//   - DEF_*   : default address width, word width and ROM read latency
//   - cnt_w() : width of a counter that must hold values 0..n-1
package rom_scan_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam int DEF_ADDR_W  = 3;
  localparam int DEF_DATA_W  = 16;
  localparam int DEF_ROM_LAT = 0;

  // Never returns 0 so a counter for a single value still has one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rom_scan_serializer_if.sv
// rom_scan_serializer_if: one-bit valid/ready serial link.
//   ser_data  - current bit, MSB of each word first
//   ser_valid - ser_data is valid
//   ser_ready - sink accepts the bit on an edge where valid and ready are high
//   ser_last  - final bit of the final word of a scan
// master = serializer side, slave = sink side.
interface rom_scan_serializer_if;
  logic ser_data;
  logic ser_valid;
  logic ser_ready;
  logic ser_last;

  modport master (
    output ser_data,
    output ser_valid,
    output ser_last,
    input  ser_ready
  );

  modport slave (
    input  ser_data,
    input  ser_valid,
    input  ser_last,
    output ser_ready
  );
endinterface

// File: rtl/rom_scan_serializer_bit_serializer.sv
// bit_serializer: parallel-load, MSB-first shift register with bit counter.
//   clk, rst_n   - clock, asynchronous active-low reset
//   load_i       - load data_i, clear the bit counter, raise valid_o
//   data_i       - parallel word to serialize
//   ready_i      - sink ready; a bit is consumed when valid_o && ready_i
//   data_o       - current bit (shift register MSB)
//   valid_o      - a word is being serialized
//   last_bit_o   - the current bit is the last bit of the word
//   accept_o     - a bit is consumed on the coming edge
module bit_serializer
  import rom_scan_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              ready_i,
  output logic              data_o,
  output logic              valid_o,
  output logic              last_bit_o,
  output logic              accept_o
);

  localparam int CNT_W = cnt_w(DATA_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              valid_q, valid_d;

  assign data_o     = shreg_q[DATA_W-1];
  assign valid_o    = valid_q;
  assign accept_o   = valid_q & ready_i;
  assign last_bit_o = valid_q && (cnt_q == CNT_LAST);

  always_comb begin
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    if (load_i) begin
      shreg_d = data_i;
      cnt_d   = '0;
      valid_d = 1'b1;
    end else if (accept_o) begin
      // Zeros shift in, so the register is empty once the word is out.
      shreg_d = {shreg_q[DATA_W-2:0], 1'b0};
      if (cnt_q == CNT_LAST) begin
        cnt_d   = '0;
        valid_d = 1'b0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg_q <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
    end
  end

endmodule

// File: rtl/rom_scan_serializer.sv
// rom_scan_serializer: scans all 2^ADDR_W words of a ROM, streams each word
// MSB-first on a one-bit valid/ready link and keeps a running checksum.
//   clk, rst_n  - clock, asynchronous active-low reset
//   start_i     - level-sampled; begins a scan when idle
//   addr_o      - registered ROM address
//   spo_i       - ROM read data, valid ROM_LAT cycles after addr_o changes
//   ser_if      - serial link (master side)
//   busy_o      - scan in progress (FETCH or SHIFT)
//   done_o      - one-cycle pulse when the scan completes
//   checksum_o  - sum of captured words modulo 2^DATA_W
module rom_scan_serializer
  import rom_scan_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int ROM_LAT = DEF_ROM_LAT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start_i,
  output logic [ADDR_W-1:0]    addr_o,
  input  logic [DATA_W-1:0]    spo_i,
  rom_scan_serializer_if.master ser_if,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [DATA_W-1:0]    checksum_o
);

  localparam int WAIT_W = cnt_w(ROM_LAT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(ROM_LAT);
  localparam logic [ADDR_W-1:0] ADDR_MAX  = {ADDR_W{1'b1}};

  state_e            state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] checksum_q;
  logic [WAIT_W-1:0] wait_q;
  logic              busy_q;
  logic              done_q;

  logic fetch_last;
  logic word_end;
  logic ser_accept;
  logic ser_last_bit;

  // spo_i is only trusted on the final FETCH cycle; earlier it still
  // reflects the previous address when the ROM has extra latency.
  assign fetch_last = (state_q == ST_FETCH) && (wait_q == WAIT_LAST);
  assign word_end   = (state_q == ST_SHIFT) && ser_accept && ser_last_bit;

  bit_serializer #(
    .DATA_W (DATA_W)
  ) u_bit_serializer (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (fetch_last),
    .data_i     (spo_i),
    .ready_i    (ser_if.ser_ready),
    .data_o     (ser_if.ser_data),
    .valid_o    (ser_if.ser_valid),
    .last_bit_o (ser_last_bit),
    .accept_o   (ser_accept)
  );

  assign ser_if.ser_last = (state_q == ST_SHIFT) && ser_last_bit && (addr_q == ADDR_MAX);

  assign addr_o     = addr_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign checksum_o = checksum_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      checksum_q <= '0;
      wait_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            addr_q     <= '0;
            checksum_q <= '0;
            wait_q     <= '0;
            busy_q     <= 1'b1;
            state_q    <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          if (fetch_last) begin
            checksum_q <= checksum_q + spo_i;
            state_q    <= ST_SHIFT;
          end else begin
            wait_q <= wait_q + WAIT_W'(1);
          end
        end
        ST_SHIFT: begin
          if (word_end) begin
            if (addr_q == ADDR_MAX) begin
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= ST_DONE;
            end else begin
              addr_q  <= addr_q + ADDR_W'(1);
              wait_q  <= '0;
              state_q <= ST_FETCH;
            end
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
